// File: rtl/rx_controller.sv
//------------------------------------------------------------------------------
// rx_controller : 8N1 UART receiver, LSB first, mid-bit sampling, framing check
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rx_controller #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       CLK_50M,
  input  logic       reset_n,
  input  logic       Din,
  output logic [7:0] Dout,
  output logic       valid,
  output logic       busy,
  output logic       frame_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          sync1;
  logic          rx_s;
  logic          rx_prev;

  always_ff @(posedge CLK_50M) begin
    if (!reset_n) begin
      state     <= IDLE;
      counter   <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      Dout      <= 8'h00;
      valid     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1   <= Din;
      rx_s    <= sync1;
      rx_prev <= rx_s;
      valid   <= 1'b0;

      case (state)
        IDLE: begin
          counter <= '0;
          // Edge-based start so a line stuck low cannot retrigger
          if (rx_prev && !rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (counter == HALF_LAST) begin
            counter <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            counter <= counter + CW'(1);
          end
        end

        DATA: begin
          if (counter == BIT_LAST) begin
            counter            <= '0;
            shift_reg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            counter <= counter + CW'(1);
          end
        end

        STOP: begin
          if (counter == BIT_LAST) begin
            counter <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
            if (rx_s) begin
              Dout      <= shift_reg;
              valid     <= 1'b1;
              frame_err <= 1'b0;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            counter <= counter + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rx_controller.sv
//------------------------------------------------------------------------------
// tb_rx_controller : scoreboard bench for rx_controller (16 clocks per bit)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rx_controller;

  localparam int CPB  = 16;
  localparam int HALF = 8;
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  logic       clk;
  logic       reset_n;
  logic       din;
  logic [7:0] dout;
  logic       valid;
  logic       busy;
  logic       frame_err;

  int total;
  int bad;
  int cyc;
  int valid_cnt;
  logic valid_d;

  logic [7:0] exp_q[$];
  int         start_q[$];

  rx_controller #(
    .CLKS_PER_BIT(CPB),
    .HALF_BIT    (HALF)
  ) dut (
    .CLK_50M  (clk),
    .reset_n  (reset_n),
    .Din      (din),
    .Dout     (dout),
    .valid    (valid),
    .busy     (busy),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: each valid pulse retires the oldest expected byte
  initial begin
    valid_cnt = 0;
    valid_d   = 1'b0;
  end
  always @(negedge clk) begin
    logic [7:0] e;
    int         s;
    if (valid) begin
      valid_cnt++;
      if (valid_d) check_val("valid_width", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        check_val("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        s = start_q.pop_front();
        check_val("dout", {24'd0, dout}, {24'd0, e});
        check_val("latency", 32'(cyc - s), 32'(LAT));
        check_val("busy_at_valid", {31'd0, busy}, 32'd0);
        check_val("ferr_at_valid", {31'd0, frame_err}, 32'd0);
      end
    end
    valid_d = valid;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic expect_ok);
    if (expect_ok) begin
      exp_q.push_back(b);
      start_q.push_back(cyc);
    end
    din = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      din = b[i];
      repeat (CPB) @(negedge clk);
    end
    din = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vc;
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    din     = 1'b1;

    // Reset state
    repeat (5) @(negedge clk);
    check_val("rst_dout", {24'd0, dout}, 32'h00);
    check_val("rst_valid", {31'd0, valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_ferr", {31'd0, frame_err}, 32'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Good frame 0xAC, busy sampled mid-frame
    vc = valid_cnt;
    fork
      send_frame(8'hAC, 1'b1, 1'b1);
      begin
        repeat (40) @(negedge clk);
        check_val("busy_midframe", {31'd0, busy}, 32'd1);
      end
    join
    repeat (20) @(negedge clk);
    check_val("ac_pulses", 32'(valid_cnt - vc), 32'd1);
    check_val("ac_dout", {24'd0, dout}, 32'hAC);
    check_val("ac_ferr", {31'd0, frame_err}, 32'd0);

    // Short low glitch aborts at the mid-start sample
    vc  = valid_cnt;
    din = 1'b0;
    repeat (4) @(negedge clk);
    din = 1'b1;
    check_val("glitch_busy_hi", {31'd0, busy}, 32'd1);
    repeat (16) @(negedge clk);
    check_val("glitch_busy_lo", {31'd0, busy}, 32'd0);
    check_val("glitch_no_valid", 32'(valid_cnt - vc), 32'd0);
    check_val("glitch_dout", {24'd0, dout}, 32'hAC);
    check_val("glitch_ferr", {31'd0, frame_err}, 32'd0);

    // Bad stop bit, then recovery with a good frame
    vc = valid_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    din = 1'b1;
    repeat (20) @(negedge clk);
    check_val("bad_stop_ferr", {31'd0, frame_err}, 32'd1);
    check_val("bad_stop_dout", {24'd0, dout}, 32'hAC);
    check_val("bad_stop_no_valid", 32'(valid_cnt - vc), 32'd0);
    check_val("bad_stop_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h55, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check_val("recover_dout", {24'd0, dout}, 32'h55);
    check_val("recover_ferr", {31'd0, frame_err}, 32'd0);
    check_val("recover_pulses", 32'(valid_cnt - vc), 32'd1);

    // Back-to-back frames with no idle gap
    vc = valid_cnt;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check_val("b2b_pulses", 32'(valid_cnt - vc), 32'd2);
    check_val("b2b_dout", {24'd0, dout}, 32'hFF);

    // Reset pulse mid-DATA of an 0xA5 frame
    vc  = valid_cnt;
    din = 1'b0;
    repeat (CPB) @(negedge clk);
    din = 1'b1;
    repeat (CPB) @(negedge clk);
    din = 1'b0;
    repeat (10) @(negedge clk);
    check_val("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    din     = 1'b1;
    check_val("midrst_dout", {24'd0, dout}, 32'h00);
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    check_val("midrst_valid", {31'd0, valid}, 32'd0);
    check_val("midrst_ferr", {31'd0, frame_err}, 32'd0);
    repeat (CPB * 10) @(negedge clk);
    check_val("midrst_no_valid", 32'(valid_cnt - vc), 32'd0);
    check_val("midrst_idle", {31'd0, busy}, 32'd0);
    send_frame(8'hA5, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check_val("a5_dout", {24'd0, dout}, 32'hA5);
    check_val("a5_pulses", 32'(valid_cnt - vc), 32'd1);

    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
